// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues word requests to a variable-latency
// memory and buffers responses in a 2-entry queue. Optional macro FETCH_PERF_EN adds a push counter.
module fetch_queue #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_done,
   output logic [15:0] instr_out,
   output logic [15:0] pc_plus2_out,
   output logic        valid_out,
   output logic        halted,
   output logic [15:0] fetch_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic        discard_q, discard_d;
   logic [1:0]  count_q, count_d;
   logic [15:0] instr_q [2];
   logic [15:0] instr_d [2];
   logic [15:0] pp2_q [2];
   logic [15:0] pp2_d [2];

   logic        pop, push, halt_hit;
   logic [1:0]  count_after;
   logic [15:0] next_addr;

   // A redirect flushes the queue, so neither a pop nor a push survives it.
   assign pop       = (count_q != 2'd0) && !stall && !redirect_en;
   assign push      = (state_q == S_WAIT) && imem_done && !discard_q && !redirect_en;
   assign halt_hit  = (imem_rdata[15:11] == HALT_OPCODE);
   assign next_addr = req_addr_q + 16'd2;

   always_comb begin
      count_after = count_q;
      if (push && !pop) begin
         count_after = count_q + 2'd1;
      end else if (pop && !push) begin
         count_after = count_q - 2'd1;
      end
   end

   always_comb begin
      count_d = count_after;
      instr_d = instr_q;
      pp2_d   = pp2_q;
      if (redirect_en) begin
         count_d = 2'd0;
      end else if (pop && !push) begin
         instr_d[0] = instr_q[1];
         pp2_d[0]   = pp2_q[1];
      end else if (push && !pop) begin
         if (count_q == 2'd0) begin
            instr_d[0] = imem_rdata;
            pp2_d[0]   = next_addr;
         end else begin
            instr_d[1] = imem_rdata;
            pp2_d[1]   = next_addr;
         end
      end else if (push && pop) begin
         // Full queue shifts the tail forward; a single entry is simply replaced.
         if (count_q == 2'd2) begin
            instr_d[0] = instr_q[1];
            pp2_d[0]   = pp2_q[1];
            instr_d[1] = imem_rdata;
            pp2_d[1]   = next_addr;
         end else begin
            instr_d[0] = imem_rdata;
            pp2_d[0]   = next_addr;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      discard_d  = discard_q;
      case (state_q)
         S_IDLE: begin
            if (count_after < 2'd2) begin
               state_d    = S_WAIT;
               req_addr_d = pc_q;
            end
         end
         S_WAIT: begin
            if (imem_done) begin
               if (discard_q) begin
                  state_d   = S_IDLE;
                  discard_d = 1'b0;
               end else begin
                  pc_d = next_addr;
                  if (halt_hit) begin
                     state_d = S_HALTED;
                  end else if (count_after < 2'd2) begin
                     req_addr_d = next_addr;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: ;
      endcase
      // An in-flight request cannot be cancelled, so its response is marked for dropping.
      if (redirect_en) begin
         pc_d = redirect_pc;
         if ((state_q == S_WAIT) && !imem_done) begin
            state_d    = S_WAIT;
            req_addr_d = req_addr_q;
            discard_d  = 1'b1;
         end else begin
            state_d    = S_IDLE;
            req_addr_d = req_addr_q;
            discard_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= 16'h0000;
         discard_q  <= 1'b0;
         count_q    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= 16'h0000;
            pp2_q[i]   <= 16'h0000;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         for (int i = 0; i < 2; i++) begin
            instr_q[i] <= instr_d[i];
            pp2_q[i]   <= pp2_d[i];
         end
      end
   end

   assign imem_req     = (state_q == S_WAIT);
   assign imem_addr    = imem_req ? req_addr_q : 16'h0000;
   assign valid_out    = (count_q != 2'd0);
   assign instr_out    = valid_out ? instr_q[0] : 16'h0000;
   assign pc_plus2_out = valid_out ? pp2_q[0] : 16'h0000;
   assign halted       = (state_q == S_HALTED);

`ifdef FETCH_PERF_EN
   logic [15:0] fetch_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= 16'h0000;
      end else if (push) begin
         fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`else
   assign fetch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed multi-cycle sequences and a
// randomized run scored against the program-order instruction stream.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, redirect_en, stall, imem_done;
   logic [15:0] redirect_pc, imem_rdata;
   logic        imem_req, valid_out, halted;
   logic [15:0] imem_addr, instr_out, pc_plus2_out, fetch_cnt;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_done(imem_done), .instr_out(instr_out),
      .pc_plus2_out(pc_plus2_out), .valid_out(valid_out), .halted(halted),
      .fetch_cnt(fetch_cnt)
   );

   int          checks = 0;
   int          errors = 0;
   int          lat_cfg, lat_left;
   bit          busy, mode_flat, allow_halt;
   logic [15:0] halt_addr;

   typedef struct {
      logic        st;
      logic        rd;
      logic [15:0] rpc;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [15:0] e_pp2;
      logic        e_halt;
   } vec_t;

   vec_t vecs [9];

   // Instruction memory contents as a pure function of the address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] h;
      if (a == halt_addr) return 16'h0000;
      if (mode_flat) return 16'h4000;
      h = a * 16'h6F4B + 16'h1234;
      if (!allow_halt) h[15] = 1'b1;
      return h;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic mem_drive();
      if (imem_req) begin
         if (!busy) begin
            busy     = 1'b1;
            lat_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
         end
         if (lat_left == 0) begin
            imem_done  = 1'b1;
            imem_rdata = mem_word(imem_addr);
            busy       = 1'b0;
         end else begin
            lat_left--;
            imem_done  = 1'b0;
            imem_rdata = 16'($urandom);
         end
      end else begin
         imem_done  = 1'b0;
         imem_rdata = 16'($urandom);
      end
   endtask

   task automatic go(input logic st, input logic rd, input logic [15:0] rpc);
      @(posedge clk);
      #1;
      stall       = st;
      redirect_en = rd;
      redirect_pc = rpc;
      mem_drive();
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      busy = 1'b0;
      go(1'b0, 1'b0, 16'h0000);
      go(1'b0, 1'b0, 16'h0000);
      chk("reset.req",      16'(imem_req), 16'h0000);
      chk("reset.addr",     imem_addr,     16'h0000);
      chk("reset.valid",    16'(valid_out), 16'h0000);
      chk("reset.instr",    instr_out,     16'h0000);
      chk("reset.pc2",      pc_plus2_out,  16'h0000);
      chk("reset.halted",   16'(halted),   16'h0000);
      chk("reset.fetchcnt", fetch_cnt,     16'h0000);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_addr, prev_addr, rpc, w, exp_cnt;
      logic        prev_req, prev_done, st, rd, halt_seen;
      int          idle, halt_wait, npop, nred;
      bit          found;

      rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
      imem_done = 1'b0; imem_rdata = 16'h0000;
      lat_cfg = 0; lat_left = 0; busy = 1'b0;
      mode_flat = 1'b1; allow_halt = 1'b0; halt_addr = 16'hFFFF;

      // Zero-latency back-to-back fetch, then a redirect to 0xFFFE that wraps.
      vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h4000, 16'h0004, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h4000, 16'h0006, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0008, 1'b1, 16'h4000, 16'h0008, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h4000, 16'h0000, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002, 1'b0};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         go(vecs[i].st, vecs[i].rd, vecs[i].rpc);
         chk($sformatf("vec%0d.req", i),    16'(imem_req),  16'(vecs[i].e_req));
         chk($sformatf("vec%0d.addr", i),   imem_addr,      vecs[i].e_addr);
         chk($sformatf("vec%0d.valid", i),  16'(valid_out), 16'(vecs[i].e_valid));
         chk($sformatf("vec%0d.instr", i),  instr_out,      vecs[i].e_instr);
         chk($sformatf("vec%0d.pc2", i),    pc_plus2_out,   vecs[i].e_pp2);
         chk($sformatf("vec%0d.halted", i), 16'(halted),    16'(vecs[i].e_halt));
         $display("vec %0d: req=%b addr=%h valid=%b instr=%h pc2=%h halted=%b",
                  i, imem_req, imem_addr, valid_out, instr_out, pc_plus2_out, halted);
      end

      // Latency 3 with decode stalled: queue fills to two, then fetching pauses.
      mode_flat = 1'b0; lat_cfg = 3;
      do_reset();
      repeat (20) go(1'b1, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         go(1'b1, 1'b0, 16'h0000);
         chk("stall.noreq", 16'(imem_req), 16'h0000);
      end
      chk("stall.valid", 16'(valid_out), 16'h0001);
      chk("stall.head",  instr_out,      mem_word(16'h0000));
      go(1'b0, 1'b0, 16'h0000);
      chk("stall.pop0.instr", instr_out,    mem_word(16'h0000));
      chk("stall.pop0.pc2",   pc_plus2_out, 16'h0002);
      go(1'b0, 1'b0, 16'h0000);
      chk("stall.pop1.instr", instr_out,    mem_word(16'h0002));
      chk("stall.pop1.pc2",   pc_plus2_out, 16'h0004);
      chk("stall.resume.req",  16'(imem_req), 16'h0001);
      chk("stall.resume.addr", imem_addr,     16'h0004);
      $display("seq stall: resumed fetch at %h", imem_addr);

      // Redirect while the request to 0x0006 is outstanding.
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         go(1'b0, 1'b0, 16'h0000);
         if (imem_req && imem_addr == 16'h0006) found = 1'b1;
      end
      chk("redir.found6", 16'(found), 16'h0001);
      go(1'b0, 1'b1, 16'h0100);
      chk("redir.addr_hold", imem_addr, 16'h0006);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         go(1'b0, 1'b0, 16'h0000);
         if (imem_req && imem_addr == 16'h0100) begin
            found = 1'b1;
         end else begin
            chk("redir.valid", 16'(valid_out), 16'h0000);
            if (imem_req) chk("redir.hold", imem_addr, 16'h0006);
         end
      end
      chk("redir.found100", 16'(found), 16'h0001);
      chk("redir.novalid", 16'(valid_out), 16'h0000);
`ifdef FETCH_PERF_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      chk("redir.fetchcnt", fetch_cnt, exp_cnt);
      $display("seq redirect: next fetch %h fetch_cnt=%0d", imem_addr, fetch_cnt);

      // HALT word at 0x0008, then redirect to 0x0020.
      mode_flat = 1'b1; halt_addr = 16'h0008; lat_cfg = 0;
      do_reset();
      repeat (5) go(1'b0, 1'b0, 16'h0000);
      go(1'b0, 1'b0, 16'h0000);
      chk("halt.halted", 16'(halted),    16'h0001);
      chk("halt.req",    16'(imem_req),  16'h0000);
      chk("halt.valid",  16'(valid_out), 16'h0001);
      chk("halt.instr",  instr_out,      16'h0000);
      chk("halt.pc2",    pc_plus2_out,   16'h000A);
      for (int i = 0; i < 3; i++) begin
         go(1'b0, 1'b0, 16'h0000);
         chk("halt.stay",   16'(halted),    16'h0001);
         chk("halt.noreq",  16'(imem_req),  16'h0000);
         chk("halt.drain",  16'(valid_out), 16'h0000);
      end
      go(1'b0, 1'b1, 16'h0020);
      go(1'b0, 1'b0, 16'h0000);
      chk("halt.cleared", 16'(halted), 16'h0000);
      go(1'b0, 1'b0, 16'h0000);
      chk("halt.refetch.req",  16'(imem_req), 16'h0001);
      chk("halt.refetch.addr", imem_addr,     16'h0020);
      $display("seq halt: refetch at %h", imem_addr);
      halt_addr = 16'hFFFF;

      // Randomized run scored against the in-order instruction stream.
      mode_flat = 1'b0; allow_halt = 1'b1; lat_cfg = -1;
      do_reset();
      exp_addr = 16'h0000; halt_seen = 1'b0; idle = 0; halt_wait = 0; npop = 0; nred = 0;
      prev_req = 1'b0; prev_done = 1'b0; prev_addr = 16'h0000;
      for (int n = 0; n < 4000; n++) begin
         st  = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 39) == 0) || (halt_wait > 6);
         rpc = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF8 + 16'(2 * $urandom_range(0, 3)))
                                             : (16'($urandom) & 16'hFFFE);
         go(st, rd, rpc);
         if (prev_req && !prev_done) begin
            chk("rnd.req_hold",  16'(imem_req), 16'h0001);
            chk("rnd.addr_hold", imem_addr,     prev_addr);
         end
         if (halted) chk("rnd.halt_noreq", 16'(imem_req), 16'h0000);
         if (halt_seen) begin
            chk("rnd.halted",  16'(halted),    16'h0001);
            chk("rnd.drained", 16'(valid_out), 16'h0000);
            halt_wait++;
         end
         if (rd) begin
            exp_addr = rpc; halt_seen = 1'b0; halt_wait = 0; idle = 0; nred++;
         end else if (valid_out && !st) begin
            w = mem_word(exp_addr);
            chk("rnd.instr", instr_out,    w);
            chk("rnd.pc2",   pc_plus2_out, 16'(exp_addr + 16'd2));
            if (w[15:11] == 5'b00000) halt_seen = 1'b1;
            exp_addr = exp_addr + 16'd2;
            idle = 0;
            npop++;
         end else if (st || halt_seen) begin
            idle = 0;
         end else begin
            idle++;
            if (idle > 24) begin
               chk("rnd.progress", 16'(idle), 16'd0);
               idle = 0;
            end
         end
         prev_req = imem_req; prev_done = imem_done; prev_addr = imem_addr;
      end
      $display("seq random: %0d instructions delivered, %0d redirects", npop, nred);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
